// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues word reads to instruction memory (req/ack)
// and presents fetched instructions to decode (valid/ready), honouring redirects.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] EXC_VEC  = 32'h0040_0004
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    input  logic        i_redir_valid,
    input  logic [31:0] i_redir_target,
    input  logic        i_exc,
    output logic        o_misalign,
    output logic [31:0] o_pc
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_HOLD   = 2'd2,
        S_SQUASH = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] w_next_pc;
    logic [31:0] r_pend;
    logic [31:0] w_next_pend;
    logic [31:0] r_inst;
    logic [31:0] w_next_inst;
    logic [31:0] r_inst_pc;
    logic [31:0] w_next_inst_pc;
    logic        r_imem_req;
    logic        r_inst_valid;
    logic        r_misalign;
    logic        w_redir;
    logic        w_taken;
    logic        w_misalign;
    logic [31:0] w_tgt;

    // Next-state, next-PC and capture logic; exceptions outrank branch redirects.
    always_comb begin
        w_next_state   = r_state;
        w_next_pc      = r_pc;
        w_next_pend    = r_pend;
        w_next_inst    = r_inst;
        w_next_inst_pc = r_inst_pc;
        w_taken        = 1'b0;
        w_redir        = i_redir_valid | i_exc;
        w_tgt          = i_exc ? EXC_VEC : {i_redir_target[31:2], 2'b00};
        case (r_state)
            S_IDLE: begin
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                if (w_redir) begin
                    w_taken = 1'b1;
                    if (i_imem_ack) begin
                        w_next_pc = w_tgt;
                    end else begin
                        // read already in flight: remember where to go once it drains
                        w_next_pend  = w_tgt;
                        w_next_state = S_SQUASH;
                    end
                end else if (i_imem_ack) begin
                    w_next_inst    = i_imem_rdata;
                    w_next_inst_pc = r_pc;
                    w_next_state   = S_HOLD;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_HOLD: begin
                if (w_redir) begin
                    w_taken      = 1'b1;
                    w_next_pc    = w_tgt;
                    w_next_state = S_FETCH;
                end else if (i_inst_ready) begin
                    w_next_pc    = r_pc + 32'd4;
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_HOLD;
                end
            end
            S_SQUASH: begin
                w_taken = w_redir;
                if (i_imem_ack) begin
                    w_next_pc    = w_redir ? w_tgt : r_pend;
                    w_next_state = S_FETCH;
                end else if (w_redir) begin
                    w_next_pend = w_tgt;
                end else begin
                    w_next_state = S_SQUASH;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        w_misalign = w_taken & i_redir_valid & ~i_exc & (i_redir_target[1:0] != 2'b00);
    end

    // State, PC and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_pend       <= 32'd0;
            r_inst       <= 32'd0;
            r_inst_pc    <= 32'd0;
            r_imem_req   <= 1'b0;
            r_inst_valid <= 1'b0;
            r_misalign   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_pc         <= w_next_pc;
            r_pend       <= w_next_pend;
            r_inst       <= w_next_inst;
            r_inst_pc    <= w_next_inst_pc;
            r_imem_req   <= (w_next_state == S_FETCH) || (w_next_state == S_SQUASH);
            r_inst_valid <= (w_next_state == S_HOLD);
            r_misalign   <= w_misalign;
        end
    end

    assign o_imem_req   = r_imem_req;
    assign o_imem_addr  = r_pc;
    assign o_pc         = r_pc;
    assign o_inst       = r_inst;
    assign o_inst_pc    = r_inst_pc;
    assign o_inst_valid = r_inst_valid;
    assign o_misalign   = r_misalign;

endmodule
